// File: rtl/nd_2to1_arb.sv
// Merges messages from two 4-phase producers onto one 4-phase consumer channel, round-robin.
// Latency: producer ack 1 edge after req is sampled; output req 1 edge after the buffer fills.
// Backpressure: one-deep buffer per input; a full buffer holds its producer's req unacked until the output frees it.
module nd_2to1_arb #(
    parameter int ASZ        = 8,
    parameter int DSZ        = 8,
    parameter int RSZ        = 4,
    parameter int FIRST_PRIO = 0
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req_in,
    output logic           rcv0_ack_out,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv1_req_in,
    output logic           rcv1_ack_out,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    output logic           snd0_req_out,
    input  logic           snd0_ack_in,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red
);

    localparam int   MW        = 2 * ASZ + DSZ + RSZ;
    // last_grant starts on the input that does NOT have first priority
    localparam logic LAST_INIT = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ready;
    logic [1:0]      r_ack;
    logic [1:0]      r_full;
    logic [MW-1:0]   r_buf0;
    logic [MW-1:0]   r_buf1;
    logic [MW-1:0]   r_snd_msg;
    logic            r_snd_req;
    logic            r_grant;
    logic            r_last;

    logic [1:0]      w_req;
    logic [MW-1:0]   w_msg0;
    logic [MW-1:0]   w_msg1;
    logic [1:0]      w_accept;
    logic [1:0]      w_release;
    logic            w_free;
    logic [1:0]      w_free_vec;
    logic            w_grant_vld;
    logic            w_grant_sel;

    assign w_req      = {rcv1_req_in, rcv0_req_in};
    assign w_msg0     = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign w_msg1     = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};

    // New accept needs req high, previous ack already dropped, and an empty buffer
    assign w_accept   = {2{r_ready}} & w_req & ~r_ack & ~r_full;
    assign w_release  = {2{r_ready}} & ~w_req & r_ack;

    // Consumer ack in SEND retires the granted buffer
    assign w_free     = r_ready & (r_state == S_SEND) & snd0_ack_in;
    assign w_free_vec = {w_free & r_grant, w_free & ~r_grant};

    // Both full: alternate away from the last served input; otherwise take whichever is full
    assign w_grant_vld = r_ready & (r_state == S_IDLE) & (|r_full);
    assign w_grant_sel = (&r_full) ? ~r_last : r_full[1];

    // Block becomes ready on the first edge after reset release
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) r_ready <= 1'b0;
        else            r_ready <= 1'b1;
    end

    // Per-input handshake and buffer occupancy
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            r_ack  <= 2'b00;
            r_full <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_accept[k]) begin
                    r_full[k] <= 1'b1;
                    r_ack[k]  <= 1'b1;
                end else begin
                    if (w_free_vec[k]) r_full[k] <= 1'b0;
                    if (w_release[k])  r_ack[k]  <= 1'b0;
                end
            end
        end
    end

    // Message payload is captured only on the accept edge
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_accept[0]) r_buf0 <= w_msg0;
            if (w_accept[1]) r_buf1 <= w_msg1;
        end
    end

    // Output FSM state register
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Output FSM next state: IDLE grants, SEND waits ack high, DROP waits ack low
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld)                 w_state_nxt = S_SEND;
            S_SEND:  if (w_free)                      w_state_nxt = S_DROP;
            S_DROP:  if (r_ready && !snd0_ack_in)     w_state_nxt = S_IDLE;
            default:                                  w_state_nxt = S_IDLE;
        endcase
    end

    // Output message, request and round-robin history; payload only changes on a grant
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            r_snd_msg <= '0;
            r_snd_req <= 1'b0;
            r_grant   <= 1'b0;
            r_last    <= LAST_INIT;
        end else if (w_grant_vld) begin
            r_snd_msg <= w_grant_sel ? r_buf1 : r_buf0;
            r_snd_req <= 1'b1;
            r_grant   <= w_grant_sel;
        end else if (w_free) begin
            r_snd_req <= 1'b0;
            r_last    <= r_grant;
        end
    end

    assign gch_ready    = r_ready;
    assign rcv0_ack_out = r_ack[0];
    assign rcv1_ack_out = r_ack[1];
    assign snd0_req_out = r_snd_req;
    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = r_snd_msg;

endmodule
